// File: rtl/pfd_pkg.sv
// Shared constants and types for the phase/frequency detector.
// Field positions of the setting output, direction encoding and default synchronizer depth.
package pfd_pkg;

   localparam int SET_ACTIVE_BIT      = 0;
   localparam int SET_DIR_BIT         = 1;
   localparam int DEFAULT_SYNC_STAGES = 2;

   typedef enum logic {
      DIR_INC = 1'b0,
      DIR_DEC = 1'b1
   } pfd_dir_e;

endpackage

// File: rtl/pfd_edge_sync.sv
// Optional input synchronizer plus rising-edge detector for one PFD input.
// Macro PFD_INPUT_SYNC_EN inserts a SYNC_STAGES-deep flop chain ahead of edge detection.
module pfd_edge_sync
   import pfd_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic clk,
   input  logic nrst,
   input  logic i_in,
   output logic o_rise
);

   logic w_sampled;
   logic r_prev;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_badSyncStages
      $error("pfd_edge_sync: SYNC_STAGES must be in 2..4");
   end

`ifdef PFD_INPUT_SYNC_EN
   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (nrst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      end
   end

   assign w_sampled = r_sync[SYNC_STAGES-1];
`else
   assign w_sampled = i_in;
`endif

   // Loading the current level during reset means a level that is already high is never seen as an edge.
   always_ff @(posedge clk) begin
      r_prev <= w_sampled;
   end

   assign o_rise = w_sampled & ~r_prev & ~nrst;

endmodule

// File: rtl/phase_freq_detector.sv
// Tri-state phase/frequency detector producing exclusive UP/DN pulses and a setting summary.
// Define PFD_INPUT_SYNC_EN to synchronize link/vco through SYNC_STAGES flops before edge detection.
module phase_freq_detector
   import pfd_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic       clk,
   input  logic       nrst,
   input  logic       link,
   input  logic       vco,
   output logic [1:0] setting,
   output logic       up,
   output logic       dn,
   output logic       upb,
   output logic       dnb
);

   logic     w_riseLink;
   logic     w_riseVco;
   logic     r_up;
   logic     r_dn;
   pfd_dir_e r_dir;

   pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_linkSync (
      .clk    (clk),
      .nrst   (nrst),
      .i_in   (link),
      .o_rise (w_riseLink)
   );

   pfd_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vcoSync (
      .clk    (clk),
      .nrst   (nrst),
      .i_in   (vco),
      .o_rise (w_riseVco)
   );

   // An edge from the lagging input closes the pulse; an edge from the leading input keeps it open.
   always_ff @(posedge clk) begin
      if (nrst) begin
         r_up  <= 1'b0;
         r_dn  <= 1'b0;
         r_dir <= DIR_INC;
      end else begin
         case ({w_riseLink, w_riseVco})
            2'b11: begin
               r_up <= 1'b0;
               r_dn <= 1'b0;
            end
            2'b10: begin
               if (r_dn) begin
                  r_up <= 1'b0;
                  r_dn <= 1'b0;
               end else begin
                  r_up  <= 1'b1;
                  r_dir <= DIR_INC;
               end
            end
            2'b01: begin
               if (r_up) begin
                  r_up <= 1'b0;
                  r_dn <= 1'b0;
               end else begin
                  r_dn  <= 1'b1;
                  r_dir <= DIR_DEC;
               end
            end
            default: begin
               r_up <= r_up;
               r_dn <= r_dn;
            end
         endcase
      end
   end

   assign up                      = r_up;
   assign dn                      = r_dn;
   assign upb                     = ~r_up;
   assign dnb                     = ~r_dn;
   assign setting[SET_ACTIVE_BIT] = r_up | r_dn;
   assign setting[SET_DIR_BIT]    = r_dir;

endmodule

// File: tb/tb_phase_freq_detector.sv
// Self-checking bench for phase_freq_detector (default build, inputs sampled directly).
// A lead/lag model tracks which input is ahead; directed scenarios pin pulse widths with literals.
module tb_phase_freq_detector;

   logic       clk;
   logic       nrst;
   logic       link;
   logic       vco;
   logic [1:0] setting;
   logic       up;
   logic       dn;
   logic       upb;
   logic       dnb;

   int testsRun;
   int testsFailed;
   int upTotal;
   int dnTotal;

   // Model: lead = +1 reference ahead, -1 VCO ahead, 0 no error pending
   int   mLead;
   logic mDir;
   logic mPrevLink;
   logic mPrevVco;
   bit   modelValid;

   phase_freq_detector #(.SYNC_STAGES(2)) dut (
      .clk     (clk),
      .nrst    (nrst),
      .link    (link),
      .vco     (vco),
      .setting (setting),
      .up      (up),
      .dn      (dn),
      .upb     (upb),
      .dnb     (dnb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // The model follows the lead/lag rules directly on the sampled levels at each edge.
   always @(posedge clk) begin
      logic ru;
      logic rv;
      if (nrst) begin
         mLead      = 0;
         mDir       = 1'b0;
         modelValid = 1'b1;
      end else begin
         ru = link && !mPrevLink;
         rv = vco && !mPrevVco;
         if (ru && rv) begin
            mLead = 0;
         end else if (ru) begin
            if (mLead == -1) mLead = 0;
            else begin
               mLead = 1;
               mDir  = 1'b0;
            end
         end else if (rv) begin
            if (mLead == 1) mLead = 0;
            else begin
               mLead = -1;
               mDir  = 1'b1;
            end
         end
      end
      mPrevLink = link;
      mPrevVco  = vco;
   end

   // Compare DUT against the model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (modelValid) begin
         checkOutput("model_up", int'(up), int'(mLead == 1));
         checkOutput("model_dn", int'(dn), int'(mLead == -1));
         checkOutput("model_setting", int'(setting), int'({mDir, mLead != 0}));
         checkOutput("model_upb_dnb", int'({upb, dnb}), int'({mLead != 1, mLead != -1}));
         if (up) upTotal++;
         if (dn) dnTotal++;
      end
   end

   task automatic waitCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic newLink, input logic newVco, input int cycles);
      link = newLink;
      vco  = newVco;
      waitCycles(cycles);
   endtask

   initial begin
      int u0;
      int d0;
      testsRun    = 0;
      testsFailed = 0;
      upTotal     = 0;
      dnTotal     = 0;
      modelValid  = 1'b0;
      mPrevLink   = 1'b0;
      mPrevVco    = 1'b0;
      mLead       = 0;
      mDir        = 1'b0;

      // Reset with both inputs already high: no edge may follow release
      nrst = 1'b1;
      link = 1'b1;
      vco  = 1'b1;
      waitCycles(3);
      checkOutput("reset_up_dn", int'({up, dn}), 0);
      checkOutput("reset_upb_dnb", int'({upb, dnb}), 3);
      checkOutput("reset_setting", int'(setting), 0);
      nrst = 1'b0;
      waitCycles(5);
      checkOutput("post_reset_no_pulse", int'({up, dn, setting}), 0);

      // Reference leads by 7 cycles
      applyStimulus(1'b0, 1'b0, 3);
      u0 = upTotal;
      d0 = dnTotal;
      applyStimulus(1'b1, 1'b0, 3);
      checkOutput("ref_lead_setting_mid", int'(setting), 1);
      applyStimulus(1'b1, 1'b0, 4);
      applyStimulus(1'b1, 1'b1, 3);
      checkOutput("ref_lead_up_width", upTotal - u0, 7);
      checkOutput("ref_lead_dn_width", dnTotal - d0, 0);
      checkOutput("ref_lead_setting_after", int'(setting), 0);

      // VCO leads by 5 cycles
      applyStimulus(1'b0, 1'b0, 3);
      u0 = upTotal;
      d0 = dnTotal;
      applyStimulus(1'b0, 1'b1, 2);
      checkOutput("vco_lead_setting_mid", int'(setting), 3);
      applyStimulus(1'b0, 1'b1, 3);
      applyStimulus(1'b1, 1'b1, 3);
      checkOutput("vco_lead_dn_width", dnTotal - d0, 5);
      checkOutput("vco_lead_up_width", upTotal - u0, 0);
      checkOutput("vco_lead_setting_after", int'(setting), 2);

      // Coincident edges: no pulse, direction holds
      applyStimulus(1'b0, 1'b0, 2);
      u0 = upTotal;
      d0 = dnTotal;
      applyStimulus(1'b1, 1'b1, 4);
      checkOutput("coincident_widths", (upTotal - u0) + (dnTotal - d0), 0);
      checkOutput("coincident_setting", int'(setting), 2);

      // Frequency detect: two reference edges before the VCO edge
      applyStimulus(1'b0, 1'b0, 3);
      u0 = upTotal;
      applyStimulus(1'b1, 1'b0, 5);
      applyStimulus(1'b0, 1'b0, 5);
      applyStimulus(1'b1, 1'b0, 3);
      checkOutput("freq_detect_still_up", int'(up), 1);
      applyStimulus(1'b1, 1'b1, 3);
      checkOutput("freq_detect_up_width", upTotal - u0, 13);
      checkOutput("freq_detect_setting", int'(setting), 0);

      // Reset mid-pulse, then a held-high link must not count as a new edge
      applyStimulus(1'b0, 1'b0, 3);
      applyStimulus(1'b1, 1'b0, 3);
      checkOutput("midreset_pulse_on", int'(up), 1);
      nrst = 1'b1;
      waitCycles(1);
      checkOutput("midreset_cleared", int'({up, dn, setting}), 0);
      nrst = 1'b0;
      waitCycles(3);
      checkOutput("midreset_no_edge", int'(up), 0);
      applyStimulus(1'b1, 1'b1, 1);
      checkOutput("midreset_vco_edge_dn", int'({dn, setting}), 7);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         nrst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 3) == 0) link = ~link;
         if ($urandom_range(0, 3) == 0) vco = ~vco;
         waitCycles(1);
      end
      nrst = 1'b0;
      waitCycles(2);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
